// File: rtl/rf_param.sv
// Parametrised 2R/1W register file with an optional hardwired-zero register 0 and a registered illegal-write flag.
// Latency: reads are combinational (0 cycles); writes land on the next clk edge; err follows the write by 1 cycle.
// Backpressure: none; a write is accepted on every edge, and an illegal write only raises err for one cycle.
//
// Optional feature macro: RF_BYPASS_EN. When it is defined, a legal write forwards writedata to any read port
// that selects the same register in the same cycle. When it is undefined, reads see only the stored contents.

module rf_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  localparam int SELW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  input  logic [SELW-1:0]  writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             err
);

  // Register storage. Entry 0 is never written when ZERO_REG is set, so it stays at its reset value.
  logic [WIDTH-1:0] regs [DEPTH];

  logic wr_in_range;
  logic wr_is_zero;
  logic wr_legal;

  logic rd1_valid;
  logic rd2_valid;
  logic byp1;
  logic byp2;

  // Classify the write target. Non-power-of-two depths leave select codes with no register behind them.
  always_comb begin
    wr_in_range = (int'(writeregsel) < DEPTH);
    wr_is_zero  = (ZERO_REG != 0) && (writeregsel == '0);
    wr_legal    = wr_in_range && !wr_is_zero;
  end

  // Update the storage: reset clears every entry and wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write && wr_legal) begin
      regs[writeregsel] <= writedata;
    end
  end

  // Flag an illegal write for exactly one cycle. The flag is not sticky, and reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= write && !wr_legal;
    end
  end

  // Decide per port whether a stored value is visible and whether the in-flight write should be forwarded.
  always_comb begin
    rd1_valid = (int'(read1regsel) < DEPTH) && !((ZERO_REG != 0) && (read1regsel == '0));
    rd2_valid = (int'(read2regsel) < DEPTH) && !((ZERO_REG != 0) && (read2regsel == '0));
`ifdef RF_BYPASS_EN
    byp1 = write && !rst && wr_legal && (read1regsel == writeregsel);
    byp2 = write && !rst && wr_legal && (read2regsel == writeregsel);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
  end

  // Drive the read ports. An out-of-range select or the hardwired zero register reads as 0.
  always_comb begin
    read1data = '0;
    read2data = '0;
    if (byp1) begin
      read1data = writedata;
    end else if (rd1_valid) begin
      read1data = regs[read1regsel];
    end
    if (byp2) begin
      read2data = writedata;
    end else if (rd2_valid) begin
      read2data = regs[read2regsel];
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// Drives three register-file configurations from one shared stimulus stream:
// the default build, a build with a hardwired zero register, and a build with DEPTH=6.
// Each output is compared against a behavioural array model of the register file.

module tb_rf_param;

  logic        clk;
  logic        rst;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [2:0]  ws;
  logic [15:0] wd;
  logic        we;

  logic [15:0] rd1 [3];
  logic [15:0] rd2 [3];
  logic        erro [3];

  int n_cmp;
  int n_bad;

  // Reference model: one array per instance, plus the expected err for each instance.
  logic [15:0] mem  [3][8];
  logic        merr [3];
  int          dep  [3];
  int          zr   [3];

  rf_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u0 (
    .clk(clk), .rst(rst), .read1regsel(rs1), .read2regsel(rs2), .writeregsel(ws),
    .writedata(wd), .write(we), .read1data(rd1[0]), .read2data(rd2[0]), .err(erro[0]));
  rf_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(rst), .read1regsel(rs1), .read2regsel(rs2), .writeregsel(ws),
    .writedata(wd), .write(we), .read1data(rd1[1]), .read2data(rd2[1]), .err(erro[1]));
  rf_param #(.WIDTH(16), .DEPTH(6), .ZERO_REG(0)) u2 (
    .clk(clk), .rst(rst), .read1regsel(rs1), .read2regsel(rs2), .writeregsel(ws),
    .writedata(wd), .write(we), .read1data(rd1[2]), .read2data(rd2[2]), .err(erro[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int i, input logic [2:0] s);
    return (int'(s) < dep[i]) && !(zr[i] != 0 && s == 3'd0);
  endfunction

  function automatic logic [15:0] exp_rd(input int i, input logic [2:0] s);
    if (int'(s) >= dep[i]) return 16'h0;
    if (zr[i] != 0 && s == 3'd0) return 16'h0;
`ifdef RF_BYPASS_EN
    if (we && !rst && legal(i, ws) && s == ws) return wd;
`endif
    return mem[i][s];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [2:0] wsel,
                       input logic [15:0] wdat, input logic [2:0] s1, input logic [2:0] s2);
    rst = r; we = w; ws = wsel; wd = wdat; rs1 = s1; rs2 = s2;
  endtask

  // One clock cycle: apply the inputs, compare outputs before the edge, advance the model across the edge.
  task automatic step(input logic r, input logic w, input logic [2:0] wsel,
                      input logic [15:0] wdat, input logic [2:0] s1, input logic [2:0] s2);
    drive(r, w, wsel, wdat, s1, s2);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_rd1_sel%0d", i, s1), {16'h0, rd1[i]}, {16'h0, exp_rd(i, s1)});
      check($sformatf("u%0d_rd2_sel%0d", i, s2), {16'h0, rd2[i]}, {16'h0, exp_rd(i, s2)});
      check($sformatf("u%0d_err", i), {31'h0, erro[i]}, {31'h0, merr[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        for (int k = 0; k < 8; k++) mem[i][k] = 16'h0;
        merr[i] = 1'b0;
      end else begin
        if (w && legal(i, wsel)) mem[i][wsel] = wdat;
        merr[i] = w && !legal(i, wsel);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    dep = '{8, 8, 6};
    zr  = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      merr[i] = 1'b0;
      for (int k = 0; k < 8; k++) mem[i][k] = 16'h0;
    end

    // Initial reset: the contents are unknown beforehand, so nothing is compared in this cycle.
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset readback on all selects, using both ports.
    for (int s = 0; s < 8; s++) step(1'b0, 1'b0, 3'd0, 16'h0, 3'(s), 3'(7 - s));
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5);
    #1;
    check("rst_rd1_r3", {16'h0, rd1[0]}, 32'h0);
    check("rst_err", {31'h0, erro[0]}, 32'h0);

    // Two writes, then read the written registers back.
    step(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1);
    step(1'b0, 1'b1, 3'd5, 16'h1234, 3'd3, 3'd5);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5);
    #1;
    check("wr_rd1_r3", {16'h0, rd1[0]}, 32'hBEEF);
    check("wr_rd2_r5", {16'h0, rd2[0]}, 32'h1234);
    step(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd6);

    // Read and write the same register in the same cycle.
    step(1'b0, 1'b1, 3'd2, 16'h0001, 3'd0, 3'd0);
    drive(1'b0, 1'b1, 3'd2, 16'hAAAA, 3'd2, 3'd2);
    #1;
`ifdef RF_BYPASS_EN
    check("same_cyc_rd1", {16'h0, rd1[0]}, 32'hAAAA);
`else
    check("same_cyc_rd1", {16'h0, rd1[0]}, 32'h0001);
`endif
    step(1'b0, 1'b1, 3'd2, 16'hAAAA, 3'd2, 3'd2);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2);
    #1;
    check("next_cyc_rd2", {16'h0, rd2[0]}, 32'hAAAA);

    // Write to the hardwired zero register: it still reads 0, and err pulses for one cycle.
    step(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    #1;
    check("zr_rd_r0", {16'h0, rd1[1]}, 32'h0);
    check("zr_err_hi", {31'h0, erro[1]}, 32'h1);
    check("zr_u0_err_lo", {31'h0, erro[0]}, 32'h0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    check("zr_err_lo", {31'h0, erro[1]}, 32'h0);

    // Write to an out-of-range select on the DEPTH=6 instance, then out-of-range reads.
    step(1'b0, 1'b1, 3'd7, 16'h5555, 3'd6, 3'd7);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd7);
    #1;
    check("d6_err_hi", {31'h0, erro[2]}, 32'h1);
    check("d6_rd_sel6", {16'h0, rd1[2]}, 32'h0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd7);
    check("d6_err_lo", {31'h0, erro[2]}, 32'h0);
    check("d8_rd_sel7", {16'h0, rd2[0]}, 32'h5555);

    // Reset wins over a write, and it also clears a pending illegal-write flag.
    step(1'b0, 1'b1, 3'd7, 16'h1111, 3'd1, 3'd1);
    step(1'b1, 1'b1, 3'd1, 16'h7777, 3'd1, 3'd1);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1);
    #1;
    check("rst_wr_r1", {16'h0, rd1[0]}, 32'h0);
    check("rst_clr_err", {31'h0, erro[2]}, 32'h0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
